// File: rtl/image_loader.sv
// Image memory loader: buffers 32-bit bridge writes in a small FIFO and
// serialises them into 16-bit background pixels or 8-bit spritesheet bytes.
module image_loader #(
    parameter logic [31:0] BG_ADDR_BASE      = 32'h2000_0000,
    parameter logic [31:0] SPRITE_ADDR_BASE  = 32'h3000_0000,
    parameter int          WINDOW_BITS       = 20,
    parameter int          BG_PIXEL_COUNT    = 129600,
    parameter int          SPRITE_BYTE_COUNT = 32768,
    parameter int          FIFO_DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_addr,
    input  logic [31:0] bridge_wr_data,
    output logic        background_write_en,
    output logic        spritesheet_write_en,
    output logic [16:0] image_write_addr,
    output logic [15:0] image_write_data,
    output logic        busy,
    output logic        overflow
);

    localparam int IW = WINDOW_BITS;
    localparam int OW = WINDOW_BITS - 2;
    localparam int EW = 1 + OW + 32;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state;
    logic [EW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    count;
    logic           empty;
    logic           full;
    logic           is_bg;
    logic           is_sp;
    logic           push_req;
    logic           push;
    logic           pop;
    logic [EW-1:0]  head;
    logic           head_kind;
    logic [OW-1:0]  head_off;
    logic [IW-1:0]  head_base;
    logic           kind;
    logic [31:0]    shreg;
    logic [IW-1:0]  idx;
    logic [2:0]     lanes;
    logic           lane_q;
    logic [31:0]    idx_w;
    logic [31:0]    limit;
    logic           in_bounds;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^bridge_addr[1:0];

    assign is_bg = bridge_wr &&
        (bridge_addr[31:IW] == BG_ADDR_BASE[31:IW]);
    assign is_sp = bridge_wr &&
        (bridge_addr[31:IW] == SPRITE_ADDR_BASE[31:IW]);
    assign push_req = is_bg || is_sp;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));

    assign pop = !empty &&
        (state == IDLE || (state == EMIT && lanes == 3'd1));
    // Pop is evaluated before push, so a full FIFO still accepts a word
    // in the cycle it is drained.
    assign push = push_req && (!full || pop);

    assign head      = mem[rptr];
    assign head_kind = head[EW-1];
    assign head_off  = head[EW-2:32];
    assign head_base = head_kind ? {head_off, 2'b00}
                                 : {1'b0, head_off, 1'b0};

    assign idx_w     = 32'(idx);
    assign limit     = kind ? 32'(SPRITE_BYTE_COUNT) : 32'(BG_PIXEL_COUNT);
    assign in_bounds = idx_w < limit;

    assign busy = !empty || (state == EMIT) || lane_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {is_sp, bridge_addr[IW-1:2], bridge_wr_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            kind                 <= 1'b0;
            shreg                <= '0;
            idx                  <= '0;
            lanes                <= '0;
            lane_q               <= 1'b0;
            background_write_en  <= 1'b0;
            spritesheet_write_en <= 1'b0;
            image_write_addr     <= '0;
            image_write_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    lane_q               <= 1'b0;
                    background_write_en  <= 1'b0;
                    spritesheet_write_en <= 1'b0;
                end
                EMIT: begin
                    lane_q               <= 1'b1;
                    background_write_en  <= !kind && in_bounds;
                    spritesheet_write_en <= kind && in_bounds;
                    if (in_bounds) begin
                        image_write_addr <= idx[16:0];
                        image_write_data <= kind ? {8'h00, shreg[31:24]}
                                                 : shreg[31:16];
                    end
                    shreg <= kind ? (shreg << 8) : (shreg << 16);
                    idx   <= idx + 1'b1;
                    lanes <= lanes - 1'b1;
                    if (lanes == 3'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A pop reloads the lane engine, overriding the advance above.
            if (pop) begin
                state <= EMIT;
                kind  <= head_kind;
                shreg <= head[31:0];
                idx   <= head_base;
                lanes <= head_kind ? 3'd4 : 3'd2;
            end
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: latency, lane order, bounds,
// overflow and mid-operation reset.
module tb_image_loader;

    logic        clk;
    logic        reset_n;
    logic        bridge_wr;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic        background_write_en;
    logic        spritesheet_write_en;
    logic [16:0] image_write_addr;
    logic [15:0] image_write_data;
    logic        busy;
    logic        overflow;

    int n_chk;
    int n_pass;
    int cyc;

    typedef struct {
        int          c;
        logic        sp;
        logic [16:0] a;
        logic [15:0] d;
    } ev_t;

    ev_t log_q[$];

    image_loader dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .bridge_wr            (bridge_wr),
        .bridge_addr          (bridge_addr),
        .bridge_wr_data       (bridge_wr_data),
        .background_write_en  (background_write_en),
        .spritesheet_write_en (spritesheet_write_en),
        .image_write_addr     (image_write_addr),
        .image_write_data     (image_write_data),
        .busy                 (busy),
        .overflow             (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && (background_write_en || spritesheet_write_en))
            log_q.push_back('{cyc, spritesheet_write_en,
                              image_write_addr, image_write_data});
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic wr_word(logic [31:0] a, logic [31:0] d);
        @(negedge clk);
        bridge_wr      = 1'b1;
        bridge_addr    = a;
        bridge_wr_data = d;
        @(negedge clk);
        bridge_wr      = 1'b0;
    endtask

    task automatic word_test(string tag, logic [31:0] a, logic [31:0] d,
                             logic sp, logic [3:0] mask,
                             logic [16:0] a0, logic [63:0] exp_d);
        int n;
        n = sp ? 4 : 2;
        wr_word(a, d);
        chk({tag, "_busy_q"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_lat"}, 32'(background_write_en | spritesheet_write_en),
            32'd0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_bg"}, 32'(background_write_en),
                32'(!sp && mask[i]));
            chk({tag, "_sp"}, 32'(spritesheet_write_en),
                32'(sp && mask[i]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (mask[i]) begin
                chk({tag, "_addr"}, 32'(image_write_addr), 32'(a0) + i);
                chk({tag, "_data"}, 32'(image_write_data),
                    32'(exp_d[63-16*i -: 16]));
            end
        end
        @(negedge clk);
        chk({tag, "_end_en"},
            32'(background_write_en | spritesheet_write_en), 32'd0);
        chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        ev_t e;
        logic [15:0] xd;
        n_chk          = 0;
        n_pass         = 0;
        cyc            = 0;
        reset_n        = 1'b0;
        bridge_wr      = 1'b0;
        bridge_addr    = '0;
        bridge_wr_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {11'd0, background_write_en, spritesheet_write_en,
            image_write_addr, busy, overflow}, 32'd0);
        chk("rst_data", 32'(image_write_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        word_test("bg", 32'h2000_0008, 32'hF800_07E0, 1'b0, 4'b0011,
                  17'd4, 64'hF800_07E0_0000_0000);
        word_test("spr", 32'h3000_0010, 32'h1122_3344, 1'b1, 4'b1111,
                  17'd16, 64'h0011_0022_0033_0044);
        word_test("bg_edge", 32'h2003_F47C, 32'hABCD_1234, 1'b0, 4'b0011,
                  17'd129598, 64'hABCD_1234_0000_0000);
        word_test("bg_oob", 32'h2003_F480, 32'h5555_AAAA, 1'b0, 4'b0000,
                  17'd0, 64'h0);
        word_test("spr_edge", 32'h3000_7FFC, 32'hA1B2_C3D4, 1'b1, 4'b1111,
                  17'd32764, 64'h00A1_00B2_00C3_00D4);
        word_test("spr_oob", 32'h3000_8000, 32'h0102_0304, 1'b1, 4'b0000,
                  17'd0, 64'h0);

        log_q.delete();
        wr_word(32'h4000_0000, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            chk("unmap_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        chk("unmap_strobes", 32'(log_q.size()), 32'd0);
        chk("unmap_ovf", 32'(overflow), 32'd0);

        // Eight back-to-back sprite words: six fit, two are dropped.
        log_q.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bridge_wr      = 1'b1;
            bridge_addr    = 32'h3000_0000 + 32'(4 * i);
            bridge_wr_data = {8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)};
        end
        @(negedge clk);
        bridge_wr = 1'b0;
        repeat (40) @(negedge clk);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(log_q.size()), 32'd24);
        for (int k = 0; k < log_q.size() && k < 24; k++) begin
            e  = log_q[k];
            xd = {8'h00, 8'(k / 4 + 16 * (k % 4))};
            chk("ovf_kind", 32'(e.sp), 32'd1);
            chk("ovf_addr", 32'(e.a), 32'(k));
            chk("ovf_data", 32'(e.d), 32'(xd));
            chk("ovf_gap", e.c, log_q[0].c + k);
        end
        chk("ovf_busy", 32'(busy), 32'd0);

        // Reset while lane 1 of a sprite word is out, two words queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bridge_wr      = 1'b1;
            bridge_addr    = 32'h3000_0100 + 32'(4 * i);
            bridge_wr_data = 32'h8899_AABB;
        end
        @(negedge clk);
        bridge_wr = 1'b0;
        @(negedge clk);
        chk("pre_rst_sp", 32'(spritesheet_write_en), 32'd1);
        chk("pre_rst_addr", 32'(image_write_addr), 32'd257);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_outs", {11'd0, background_write_en,
            spritesheet_write_en, image_write_addr, busy, overflow}, 32'd0);
        chk("mid_rst_data", 32'(image_write_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        log_q.delete();
        repeat (10) @(negedge clk);
        chk("post_rst_strobes", 32'(log_q.size()), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ovf", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
